// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / interrupt-entry controller.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W = 2;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned DRAIN_CYCLES = 3;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] PC_SEL_NONE = 2'b00;
  localparam logic [1:0] PC_SEL_INTR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SAVE   = 2'd2,
    ST_VECTOR = 2'd3
  } intr_state_t;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Operand forwarding select for one Execute-stage source register.
module fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [1:0] src_E,
  input  logic [1:0] rd_M,
  input  logic       wr_en_regf_M,
  input  logic [1:0] rd_W,
  input  logic       wr_en_regf_W,
  output logic [1:0] fwd
);

  // Memory stage holds the newer value, so it wins over Writeback.
  always_comb begin
    fwd = FWD_RF;
    if (wr_en_regf_M && (rd_M == src_E)) begin
      fwd = FWD_MEM;
    end else if (wr_en_regf_W && (rd_W == src_E)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding, load-use stall, branch flush and interrupt entry.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] rs_D,
  input  logic [1:0] rt_D,
  input  logic [1:0] rs_E,
  input  logic [1:0] rt_E,
  input  logic [1:0] rd_E,
  input  logic       wr_en_regf_E,
  input  logic       rd_en_E,
  input  logic [1:0] rd_M,
  input  logic [1:0] rd_W,
  input  logic       wr_en_regf_M,
  input  logic       wr_en_regf_W,
  input  logic       branch_taken_E,
  input  logic       intr_req,
  output logic       stall_F,
  output logic       stall_D,
  output logic       flush_D,
  output logic       flush_E,
  output logic [1:0] fwd_a_E,
  output logic [1:0] fwd_b_E,
  output logic       save_pc,
  output logic [1:0] pc_sel_intr,
  output logic       intr_ack
);

  intr_state_t      state;
  logic [CNT_W-1:0] drain_cnt;
  logic             pending;
  logic             load_use;
  logic             intr_go;

  fwd_sel u_fwd_a (
    .src_E        (rs_E),
    .rd_M         (rd_M),
    .wr_en_regf_M (wr_en_regf_M),
    .rd_W         (rd_W),
    .wr_en_regf_W (wr_en_regf_W),
    .fwd          (fwd_a_E)
  );

  fwd_sel u_fwd_b (
    .src_E        (rt_E),
    .rd_M         (rd_M),
    .wr_en_regf_M (wr_en_regf_M),
    .rd_W         (rd_W),
    .wr_en_regf_W (wr_en_regf_W),
    .fwd          (fwd_b_E)
  );

  // Hazard terms OR'd with FSM terms; a taken branch always releases the stalls.
  always_comb begin
    load_use = rd_en_E && wr_en_regf_E && ((rd_E == rs_D) || (rd_E == rt_D));
    intr_go  = (intr_req || pending) && !branch_taken_E && !load_use;
    stall_F  = !branch_taken_E &&
               (load_use || (state == ST_DRAIN) || (state == ST_SAVE));
    stall_D  = !branch_taken_E && load_use;
    flush_D  = branch_taken_E || (state == ST_DRAIN) || (state == ST_VECTOR);
    flush_E  = branch_taken_E || load_use;
  end

  // Interrupt entry: drain the back end, push the PC, redirect to the vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      drain_cnt   <= '0;
      pending     <= 1'b0;
      intr_ack    <= 1'b0;
      save_pc     <= 1'b0;
      pc_sel_intr <= PC_SEL_NONE;
    end else begin
      intr_ack    <= (state == ST_VECTOR);
      save_pc     <= 1'b0;
      pc_sel_intr <= PC_SEL_NONE;
      if ((state != ST_IDLE) && intr_req) begin
        pending <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (intr_go) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
            pending   <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
            state     <= ST_SAVE;
            drain_cnt <= '0;
            save_pc   <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + CNT_W'(1);
          end
        end
        ST_SAVE: begin
          state       <= ST_VECTOR;
          pc_sel_intr <= PC_SEL_INTR;
        end
        ST_VECTOR: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [1:0] rs_D, rt_D, rs_E, rt_E, rd_E, rd_M, rd_W;
  logic       wr_en_regf_E, rd_en_E, wr_en_regf_M, wr_en_regf_W;
  logic       branch_taken_E, intr_req;
  logic       stall_F, stall_D, flush_D, flush_E;
  logic [1:0] fwd_a_E, fwd_b_E;
  logic       save_pc;
  logic [1:0] pc_sel_intr;
  logic       intr_ack;

  int n_tests;
  int n_fail;
  int acks;
  int bad;

  logic [5:0] exp_seq [7];

  hazard_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .rs_D           (rs_D),
    .rt_D           (rt_D),
    .rs_E           (rs_E),
    .rt_E           (rt_E),
    .rd_E           (rd_E),
    .wr_en_regf_E   (wr_en_regf_E),
    .rd_en_E        (rd_en_E),
    .rd_M           (rd_M),
    .rd_W           (rd_W),
    .wr_en_regf_M   (wr_en_regf_M),
    .wr_en_regf_W   (wr_en_regf_W),
    .branch_taken_E (branch_taken_E),
    .intr_req       (intr_req),
    .stall_F        (stall_F),
    .stall_D        (stall_D),
    .flush_D        (flush_D),
    .flush_E        (flush_E),
    .fwd_a_E        (fwd_a_E),
    .fwd_b_E        (fwd_b_E),
    .save_pc        (save_pc),
    .pc_sel_intr    (pc_sel_intr),
    .intr_ack       (intr_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {stall_F, flush_D, save_pc, pc_sel_intr, intr_ack}
  function automatic logic [7:0] obs();
    return {2'b00, stall_F, flush_D, save_pc, pc_sel_intr, intr_ack};
  endfunction

  function automatic logic [7:0] haz();
    return {4'b0000, stall_F, stall_D, flush_D, flush_E};
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_seq[0] = 6'b110000;
    exp_seq[1] = 6'b110000;
    exp_seq[2] = 6'b110000;
    exp_seq[3] = 6'b101000;
    exp_seq[4] = 6'b010100;
    exp_seq[5] = 6'b000001;
    exp_seq[6] = 6'b000000;

    reset = 1'b1;
    {rs_D, rt_D, rs_E, rt_E, rd_E, rd_M, rd_W} = '0;
    {wr_en_regf_E, rd_en_E, wr_en_regf_M, wr_en_regf_W} = '0;
    branch_taken_E = 1'b0;
    intr_req = 1'b0;
    #1;
    check("reset_fsm_outs", obs(), 8'h00);
    check("reset_hazards", haz(), 8'h00);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("reset_pending", {7'd0, dut.pending}, 8'h00);

    // Forwarding: Memory beats Writeback, then Writeback alone.
    rs_E = 2'd2; rd_M = 2'd2; wr_en_regf_M = 1'b1; rd_W = 2'd2; wr_en_regf_W = 1'b1;
    #1; check("fwd_a_mem_prio", {6'd0, fwd_a_E}, 8'h02);
    wr_en_regf_M = 1'b0;
    #1; check("fwd_a_wb", {6'd0, fwd_a_E}, 8'h01);
    rs_E = 2'd0; rt_E = 2'd0; rd_M = 2'd0; wr_en_regf_M = 1'b1; rd_W = 2'd3;
    #1; check("fwd_r0_a", {6'd0, fwd_a_E}, 8'h02);
    check("fwd_r0_b", {6'd0, fwd_b_E}, 8'h02);
    rt_E = 2'd3;
    #1; check("fwd_b_wb", {6'd0, fwd_b_E}, 8'h01);
    rt_E = 2'd1;
    #1; check("fwd_b_rf", {6'd0, fwd_b_E}, 8'h00);
    {rs_E, rt_E, rd_M, rd_W, wr_en_regf_M, wr_en_regf_W} = '0;

    // Load-use via rt_D, then branch override.
    rt_D = 2'd1; rs_D = 2'd3;
    rd_en_E = 1'b1; wr_en_regf_E = 1'b1; rd_E = 2'd1;
    #1; check("load_use_rt", haz(), 8'b1101);
    branch_taken_E = 1'b1;
    #1; check("branch_over_lu", haz(), 8'b0011);
    branch_taken_E = 1'b0; rd_E = 2'd3;
    #1; check("load_use_rs", haz(), 8'b1101);
    wr_en_regf_E = 1'b0;
    #1; check("no_lu_without_wr", haz(), 8'b0000);
    tick();
    rd_en_E = 1'b0; rd_E = 2'd0; rs_D = 2'd0; rt_D = 2'd0;
    #1; check("lu_released", haz(), 8'b0000);

    // Interrupt blocked by a simultaneous branch stays in IDLE.
    intr_req = 1'b1; branch_taken_E = 1'b1;
    #1; check("blocked_br", haz(), 8'b0011);
    tick();
    intr_req = 1'b0; branch_taken_E = 1'b0;
    #1; check("blocked_idle", obs(), 8'h00);

    // Single interrupt entry sequence.
    intr_req = 1'b1;
    tick();
    intr_req = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check($sformatf("seq1_c%0d", i), obs(), {2'b00, exp_seq[i]});
      if (i == 1) begin
        branch_taken_E = 1'b1;
        #1; check("drain_branch", haz(), 8'b0011);
        branch_taken_E = 1'b0;
      end
      tick();
    end

    // Second request during SAVE is held and replayed after the first ack.
    intr_req = 1'b1;
    tick();
    intr_req = 1'b0;
    tick(); tick(); tick();
    check("seq2_save", obs(), 8'b101000);
    intr_req = 1'b1;
    tick();
    intr_req = 1'b0;
    check("seq2_pending", {7'd0, dut.pending}, 8'h01);
    check("seq2_vector", obs(), 8'b010100);
    acks = 0;
    for (int j = 0; j < 12; j++) begin
      tick();
      if (intr_ack) acks++;
      if (j == 1) begin
        check("seq2_redrain", obs(), 8'b110000);
        check("seq2_pend_clr", {7'd0, dut.pending}, 8'h00);
      end
    end
    check("seq2_ack_count", 8'(acks), 8'd2);

    // Reset in the 2nd DRAIN cycle abandons the sequence and the held request.
    intr_req = 1'b1;
    tick();
    tick();
    intr_req = 1'b0;
    check("rst_pre_drain", obs(), 8'b110000);
    reset = 1'b1;
    #1;
    check("rst_mid_outs", obs(), 8'h00);
    check("rst_mid_pending", {7'd0, dut.pending}, 8'h00);
    tick();
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (save_pc || intr_ack || stall_F) bad++;
    end
    check("rst_no_resume", 8'(bad), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
